keypad_events: RTL and testbench
================================

Name: keypad_events

Overview:
Front end that produces the single-cycle button-event pulses consumed by the calculator control FSM. It does three things:
- scans a 4x4 matrix keypad, debounces each press and emits exactly one event per press (no auto-repeat);
- debounces the three discrete memory buttons (MS/MR/MC);
- sits between board pins and the control block; all outputs are registered.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before advancing (sample on last cycle)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required for press and for release
CNT_W, 16, width of scan/debounce counters; must hold max(SCAN_DIV, DEBOUNCE_CYCLES)

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
row_in  in  4  keypad rows, active-high (pulldowns), asynchronous to clock
col_out  out  4  one-hot column drive, active-high
ms_btn  in  1  raw MS button, active-high
mr_btn  in  1  raw MR button
mc_btn  in  1  raw MC button
dig_in  out  1  one-cycle pulse: digit key pressed
digit  out  4  digit value 0-9, valid with dig_in, held until next dig_in
op_in  out  1  one-cycle pulse: operator key (+, -, *)
op_code  out  2  00 add, 01 sub, 10 mul; valid with op_in, held until next op_in
sub_in  out  1  one-cycle pulse: '-' key
ex_in  out  1  one-cycle pulse: '=' key
bksp_in  out  1  one-cycle pulse: backspace key
reset_in  out  1  one-cycle pulse: 'C' (clear) key
MS_in, MR_in, MC_in  out  1 each  one-cycle pulse on debounced rising edge of the matching button
LED  out  2  current scan FSM state, for debug

Behaviour:
- Reset (async, active-high):
  - col_out=4'b0001; all pulses 0; digit=0; op_code=0.
  - FSM=SCAN; counters 0; synchronisers 0.
  - Reset during any state aborts that state with no pulse emitted.
- Input synchronisation: row_in and each button go through 2-FF synchronisers. Only synchronised values are used.
- Key index = row*4 + col. Map:
  - r0: 1 2 3 +
  - r1: 4 5 6 -
  - r2: 7 8 9 *
  - r3: C 0 = BKSP
- FSM states (LED encoding): SCAN=0, DEBOUNCE=1, EMIT=2, RELEASE=3.
  - SCAN: column counter counts to SCAN_DIV-1 and then rotates col_out left, wrapping 1000->0001. On the last dwell cycle, if any synchronised row is high, latch col and the lowest-index high row, freeze col_out and go to DEBOUNCE. Otherwise advance the column.
  - DEBOUNCE: counter increments each cycle while the row pattern equals the latched one-hot row.
    - Any mismatch (release, or a different/extra row) -> SCAN, no event; the column resumes rotating from the frozen column.
    - Reaching DEBOUNCE_CYCLES -> EMIT.
  - EMIT: one cycle. Registered outputs assert in the following cycle for exactly one cycle.
    - Digit key: dig_in=1, digit=value.
    - '+' : op_in, op_code=00.
    - '-' : op_in AND sub_in in the same cycle, op_code=01.
    - '*' : op_in, op_code=10.
    - '=' : ex_in. 'C' : reset_in. BKSP : bksp_in.
    - Then go to RELEASE.
  - RELEASE: column stays frozen. Requires all rows low for DEBOUNCE_CYCLES consecutive cycles (any high row restarts the count), then -> SCAN.
- Second key pressed while one is held: ignored, since only one column is driven and the first key must release.
- Latency: a stable press to its pulse takes at most 2 (sync) + 4*SCAN_DIV + DEBOUNCE_CYCLES + 2 cycles.
- Memory buttons:
  - Each is handled by an independent debouncer: output level changes only after DEBOUNCE_CYCLES stable cycles.
  - Rising edge of the debounced level -> one-cycle MS_in/MR_in/MC_in.
  - These pulses are independent of the keypad FSM and may coincide with keypad pulses.
- No more than one keypad event per press. Holding a key produces exactly one pulse.

Decomposition:
- Shared package: key index constants (KEY_ADD, KEY_SUB, KEY_MUL, KEY_EQ, KEY_CLR, KEY_BKSP), op_code constants (OP_ADD, OP_SUB, OP_MUL) and scan FSM state encodings. The control FSM and the ALU import the same op_code constants.
- Sub-module: btn_debounce (2-FF sync + stable counter + rising-edge pulse, parameter DEBOUNCE_CYCLES). Instantiate it three times for the memory buttons.
- Matrix scan FSM stays in keypad_events.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset mid-scan: assert reset asynchronously -> col_out=0001 immediately, all pulses 0, LED=0.
- Hold row1 high while col_out=0010 for 40 cycles -> exactly one dig_in pulse with digit=5; no further pulses until rows low for 8 cycles.
- Press '-' (row1, col3) -> op_in and sub_in high in the same single cycle, op_code=01.
- Bounce: row2 high 5 cycles, low 1, high 5, then released (col 0001) -> no pulse, LED returns to 0.
- Press '=' then hold 'C' concurrently in another column -> only ex_in; reset_in is pulsed only after '=' is released and 'C' is re-scanned.
- mr_btn bouncing 3 cycles then high 20 cycles -> one MR_in pulse; keypad '8' pressed in the same window -> dig_in (digit=8) also delivered.

Source files
------------

// File: rtl/keypad_events_pkg.sv
`default_nettype none
// keypad_events_pkg: key indices, op codes and scan FSM encodings shared with control/ALU.
// Rev 1.0
package keypad_events_pkg;

   // Key index = row*4 + col
   localparam logic [3:0] KEY_ADD  = 4'd3;
   localparam logic [3:0] KEY_SUB  = 4'd7;
   localparam logic [3:0] KEY_MUL  = 4'd11;
   localparam logic [3:0] KEY_CLR  = 4'd12;
   localparam logic [3:0] KEY_EQ   = 4'd14;
   localparam logic [3:0] KEY_BKSP = 4'd15;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_EMIT     = 2'd2,
      ST_RELEASE  = 2'd3
   } scan_state_e;

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      case (oh)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic key_is_digit(input logic [3:0] key);
      return (key[1:0] != 2'd3) && (key != KEY_CLR) && (key != KEY_EQ);
   endfunction

   function automatic logic [3:0] key_digit(input logic [3:0] key);
      logic [3:0] d;
      d = 4'd0;
      case (key)
         4'd0:  d = 4'd1;
         4'd1:  d = 4'd2;
         4'd2:  d = 4'd3;
         4'd4:  d = 4'd4;
         4'd5:  d = 4'd5;
         4'd6:  d = 4'd6;
         4'd8:  d = 4'd7;
         4'd9:  d = 4'd8;
         4'd10: d = 4'd9;
         default: d = 4'd0;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_events_btn_debounce.sv
`default_nettype none
// btn_debounce: 2-FF synchroniser, stable-count debouncer and rising-edge pulse.
// Rev 1.0
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_i,
   output logic pulse_o
);

   localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

   logic             s1_q, s2_q, level_q, pulse_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= btn_i;
         s2_q    <= s1_q;
         pulse_q <= 1'b0;
         // Count only while the synchronised input disagrees with the accepted level
         if (s2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == c_deb_last) begin
            level_q <= s2_q;
            pulse_q <= s2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + c_one;
         end
      end
   end

   assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/keypad_events.sv
`default_nettype none
// keypad_events: 4x4 matrix scan/debounce plus memory-button debouncers, registered event pulses.
// Rev 1.0
module keypad_events
   import keypad_events_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   input  logic       ms_btn,
   input  logic       mr_btn,
   input  logic       mc_btn,
   output logic       dig_in,
   output logic [3:0] digit,
   output logic       op_in,
   output logic [1:0] op_code,
   output logic       sub_in,
   output logic       ex_in,
   output logic       bksp_in,
   output logic       reset_in,
   output logic       MS_in,
   output logic       MR_in,
   output logic       MC_in,
   output logic [1:0] LED
);

   localparam logic [CNT_W-1:0] c_scan_last = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

   logic [3:0]       row_s1_q, row_s2_q;
   scan_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       col_q, row_lat_q, key_q, digit_q;
   logic [1:0]       op_code_q;
   logic             dig_q, op_q, sub_q, ex_q, bksp_q, clr_q;
   logic [3:0]       row_first;

   // Lowest-index high row as a one-hot vector
   assign row_first = row_s2_q & (~row_s2_q + 4'd1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row_s1_q <= '0;
         row_s2_q <= '0;
      end else begin
         row_s1_q <= row_in;
         row_s2_q <= row_s1_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_SCAN;
         cnt_q     <= '0;
         col_q     <= 4'b0001;
         row_lat_q <= '0;
         key_q     <= '0;
         digit_q   <= '0;
         op_code_q <= OP_ADD;
         dig_q     <= 1'b0;
         op_q      <= 1'b0;
         sub_q     <= 1'b0;
         ex_q      <= 1'b0;
         bksp_q    <= 1'b0;
         clr_q     <= 1'b0;
      end else begin
         dig_q  <= 1'b0;
         op_q   <= 1'b0;
         sub_q  <= 1'b0;
         ex_q   <= 1'b0;
         bksp_q <= 1'b0;
         clr_q  <= 1'b0;
         case (state_q)
            ST_SCAN: begin
               if (cnt_q == c_scan_last) begin
                  cnt_q <= '0;
                  if (|row_s2_q) begin
                     key_q     <= {onehot_idx(row_first), onehot_idx(col_q)};
                     row_lat_q <= row_first;
                     state_q   <= ST_DEBOUNCE;
                  end else begin
                     col_q <= {col_q[2:0], col_q[3]};
                  end
               end else begin
                  cnt_q <= cnt_q + c_one;
               end
            end
            ST_DEBOUNCE: begin
               if (row_s2_q != row_lat_q) begin
                  state_q <= ST_SCAN;
                  cnt_q   <= '0;
               end else if (cnt_q == c_deb_last) begin
                  state_q <= ST_EMIT;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + c_one;
               end
            end
            ST_EMIT: begin
               if (key_is_digit(key_q)) begin
                  dig_q   <= 1'b1;
                  digit_q <= key_digit(key_q);
               end else begin
                  case (key_q)
                     KEY_ADD:  begin op_q <= 1'b1; op_code_q <= OP_ADD; end
                     KEY_SUB:  begin op_q <= 1'b1; sub_q <= 1'b1; op_code_q <= OP_SUB; end
                     KEY_MUL:  begin op_q <= 1'b1; op_code_q <= OP_MUL; end
                     KEY_EQ:   ex_q   <= 1'b1;
                     KEY_CLR:  clr_q  <= 1'b1;
                     KEY_BKSP: bksp_q <= 1'b1;
                     default:  ;
                  endcase
               end
               state_q <= ST_RELEASE;
               cnt_q   <= '0;
            end
            ST_RELEASE: begin
               if (|row_s2_q) begin
                  cnt_q <= '0;
               end else if (cnt_q == c_deb_last) begin
                  state_q <= ST_SCAN;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + c_one;
               end
            end
            default: begin
               state_q <= ST_SCAN;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ms (
      .clock(clock), .reset(reset), .btn_i(ms_btn), .pulse_o(MS_in));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mr (
      .clock(clock), .reset(reset), .btn_i(mr_btn), .pulse_o(MR_in));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mc (
      .clock(clock), .reset(reset), .btn_i(mc_btn), .pulse_o(MC_in));

   assign col_out  = col_q;
   assign dig_in   = dig_q;
   assign digit    = digit_q;
   assign op_in    = op_q;
   assign op_code  = op_code_q;
   assign sub_in   = sub_q;
   assign ex_in    = ex_q;
   assign bksp_in  = bksp_q;
   assign reset_in = clr_q;
   assign LED      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_events.sv
`default_nettype none
// tb_keypad_events: directed scenarios against a behavioural 4x4 keypad model.
// Rev 1.0
module tb_keypad_events;

   logic       clock, reset;
   logic [3:0] row_in, col_out, digit;
   logic       ms_btn, mr_btn, mc_btn;
   logic       dig_in, op_in, sub_in, ex_in, bksp_in, reset_in, MS_in, MR_in, MC_in;
   logic [1:0] op_code, LED;
   logic [15:0] keys;

   int passed, total;
   int n_dig, n_op, n_sub, n_opsub, n_ex, n_bksp, n_clr, n_ms, n_mr, n_mc;

   keypad_events #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .row_in(row_in), .col_out(col_out),
      .ms_btn(ms_btn), .mr_btn(mr_btn), .mc_btn(mc_btn),
      .dig_in(dig_in), .digit(digit), .op_in(op_in), .op_code(op_code),
      .sub_in(sub_in), .ex_in(ex_in), .bksp_in(bksp_in), .reset_in(reset_in),
      .MS_in(MS_in), .MR_in(MR_in), .MC_in(MC_in), .LED(LED));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // A pressed key connects its row to its column drive
   always_comb begin
      row_in = '0;
      for (int r = 0; r < 4; r++) row_in[r] = |(keys[r*4 +: 4] & col_out);
   end

   // Each high cycle of a pulse counts once, so a stretched pulse shows up as an extra event
   always @(negedge clock) begin
      n_dig   = n_dig   + int'(dig_in);
      n_op    = n_op    + int'(op_in);
      n_sub   = n_sub   + int'(sub_in);
      n_opsub = n_opsub + int'(op_in & sub_in);
      n_ex    = n_ex    + int'(ex_in);
      n_bksp  = n_bksp  + int'(bksp_in);
      n_clr   = n_clr   + int'(reset_in);
      n_ms    = n_ms    + int'(MS_in);
      n_mr    = n_mr    + int'(MR_in);
      n_mc    = n_mc    + int'(MC_in);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic test_reset;
      logic [9:0] pulses;
      int d0;
      reset = 1'b1;
      cyc(2);
      pulses = {dig_in, op_in, sub_in, ex_in, bksp_in, reset_in, MS_in, MR_in, MC_in, 1'b0};
      total++; if (col_out !== 4'b0001) $display("FAIL reset_col: got %b want 0001", col_out); else passed++;
      total++; if (LED !== 2'd0) $display("FAIL reset_led: got %0d want 0", LED); else passed++;
      total++; if (pulses !== 10'd0) $display("FAIL reset_pulses: got %b want 0", pulses); else passed++;
      total++; if ({digit, op_code} !== 6'd0) $display("FAIL reset_data: got digit=%0d op=%b want 0/00", digit, op_code); else passed++;
      reset = 1'b0;
      cyc(6);
      total++; if (col_out !== 4'b0010) $display("FAIL scan_dwell: got %b want 0010", col_out); else passed++;
      #2 reset = 1'b1;
      #1;
      total++; if (col_out !== 4'b0001 || LED !== 2'd0) $display("FAIL async_reset: got col=%b led=%0d want 0001/0", col_out, LED); else passed++;
      cyc(1);
      reset = 1'b0;
      keys = 16'h0001 << 5;
      for (int i = 0; i < 40 && LED !== 2'd1; i++) cyc(1);
      total++; if (LED !== 2'd1) $display("FAIL reach_debounce: got %0d want 1", LED); else passed++;
      #2 reset = 1'b1;
      #1;
      total++; if (LED !== 2'd0) $display("FAIL abort_led: got %0d want 0", LED); else passed++;
      d0 = n_dig;
      cyc(2);
      keys = '0;
      reset = 1'b0;
      cyc(40);
      total++; if (n_dig - d0 !== 0) $display("FAIL abort_no_pulse: got %0d want 0", n_dig - d0); else passed++;
   endtask

   task automatic test_digit_hold;
      int d0, o0, e0;
      d0 = n_dig; o0 = n_op; e0 = n_ex + n_clr + n_bksp;
      keys = 16'h0001 << 5;
      cyc(40);
      total++; if (n_dig - d0 !== 1) $display("FAIL hold_one_pulse: got %0d want 1", n_dig - d0); else passed++;
      total++; if (LED !== 2'd3) $display("FAIL hold_release_state: got %0d want 3", LED); else passed++;
      keys = '0;
      cyc(5);
      total++; if (LED !== 2'd3) $display("FAIL release_wait: got %0d want 3", LED); else passed++;
      cyc(20);
      total++; if (LED !== 2'd0) $display("FAIL release_done: got %0d want 0", LED); else passed++;
      total++; if (digit !== 4'd5) $display("FAIL digit5_value: got %0d want 5", digit); else passed++;
      total++; if (n_dig - d0 !== 1 || n_op - o0 !== 0 || n_ex + n_clr + n_bksp - e0 !== 0)
         $display("FAIL digit5_only: got dig=%0d op=%0d other=%0d want 1/0/0", n_dig - d0, n_op - o0, n_ex + n_clr + n_bksp - e0);
      else passed++;
   endtask

   task automatic test_ops;
      int         key_t[3]   = '{7, 3, 11};
      logic [1:0] code_t[3]  = '{2'b01, 2'b00, 2'b10};
      int         sub_t[3]   = '{1, 0, 0};
      int o0, s0, c0, d0;
      for (int k = 0; k < 3; k++) begin
         o0 = n_op; s0 = n_sub; c0 = n_opsub; d0 = n_dig;
         keys = 16'h0001 << key_t[k];
         cyc(40);
         keys = '0;
         cyc(20);
         total++; if (n_op - o0 !== 1) $display("FAIL op_count[%0d]: got %0d want 1", k, n_op - o0); else passed++;
         total++; if (op_code !== code_t[k]) $display("FAIL op_code[%0d]: got %b want %b", k, op_code, code_t[k]); else passed++;
         total++; if (n_sub - s0 !== sub_t[k] || n_opsub - c0 !== sub_t[k])
            $display("FAIL sub_pulse[%0d]: got sub=%0d coincident=%0d want %0d", k, n_sub - s0, n_opsub - c0, sub_t[k]);
         else passed++;
         total++; if (n_dig - d0 !== 0) $display("FAIL op_no_digit[%0d]: got %0d want 0", k, n_dig - d0); else passed++;
      end
   endtask

   task automatic test_bounce;
      int a0;
      a0 = n_dig + n_op + n_ex + n_clr + n_bksp;
      keys = 16'h0001 << 8;
      for (int i = 0; i < 40 && LED !== 2'd1; i++) cyc(1);
      total++; if (LED !== 2'd1) $display("FAIL bounce_enter: got %0d want 1", LED); else passed++;
      cyc(3);
      keys = '0;
      cyc(1);
      keys = 16'h0001 << 8;
      cyc(5);
      keys = '0;
      cyc(30);
      total++; if (n_dig + n_op + n_ex + n_clr + n_bksp - a0 !== 0)
         $display("FAIL bounce_no_event: got %0d want 0", n_dig + n_op + n_ex + n_clr + n_bksp - a0);
      else passed++;
      total++; if (LED !== 2'd0) $display("FAIL bounce_led: got %0d want 0", LED); else passed++;
   endtask

   task automatic test_back_to_back;
      int e0, c0;
      e0 = n_ex; c0 = n_clr;
      keys = 16'h0001 << 14;
      for (int i = 0; i < 60 && n_ex == e0; i++) cyc(1);
      total++; if (n_ex - e0 !== 1) $display("FAIL eq_pulse: got %0d want 1", n_ex - e0); else passed++;
      keys = keys | (16'h0001 << 12);
      cyc(30);
      total++; if (n_clr - c0 !== 0) $display("FAIL clr_masked: got %0d want 0", n_clr - c0); else passed++;
      keys = 16'h0001 << 12;
      for (int i = 0; i < 80 && n_clr == c0; i++) cyc(1);
      total++; if (n_clr - c0 !== 1) $display("FAIL clr_after_release: got %0d want 1", n_clr - c0); else passed++;
      keys = '0;
      cyc(20);
      total++; if (n_ex - e0 !== 1 || n_clr - c0 !== 1)
         $display("FAIL eq_clr_totals: got ex=%0d clr=%0d want 1/1", n_ex - e0, n_clr - c0);
      else passed++;
   endtask

   task automatic test_mem_buttons;
      int r0, s0, c0, d0;
      r0 = n_mr; s0 = n_ms; c0 = n_mc; d0 = n_dig;
      keys = 16'h0001 << 9;
      for (int i = 0; i < 40; i++) begin
         mr_btn = (i < 3) ? i[0] : (i < 23);
         cyc(1);
      end
      keys = '0;
      mr_btn = 1'b0;
      cyc(30);
      total++; if (n_mr - r0 !== 1) $display("FAIL mr_pulse: got %0d want 1", n_mr - r0); else passed++;
      total++; if (n_ms - s0 !== 0 || n_mc - c0 !== 0) $display("FAIL mr_isolated: got ms=%0d mc=%0d want 0/0", n_ms - s0, n_mc - c0); else passed++;
      total++; if (n_dig - d0 !== 1 || digit !== 4'd8) $display("FAIL key8_concurrent: got n=%0d digit=%0d want 1/8", n_dig - d0, digit); else passed++;
      ms_btn = 1'b1;
      cyc(20);
      ms_btn = 1'b0;
      mc_btn = 1'b1;
      cyc(5);
      mc_btn = 1'b0;
      cyc(20);
      total++; if (n_ms - s0 !== 1) $display("FAIL ms_pulse: got %0d want 1", n_ms - s0); else passed++;
      total++; if (n_mc - c0 !== 0) $display("FAIL mc_short_glitch: got %0d want 0", n_mc - c0); else passed++;
   endtask

   initial begin
      passed = 0; total = 0;
      n_dig = 0; n_op = 0; n_sub = 0; n_opsub = 0; n_ex = 0;
      n_bksp = 0; n_clr = 0; n_ms = 0; n_mr = 0; n_mc = 0;
      keys = '0; ms_btn = 1'b0; mr_btn = 1'b0; mc_btn = 1'b0;
      reset = 1'b1;
      test_reset;
      test_digit_hold;
      test_ops;
      test_bounce;
      test_back_to_back;
      test_mem_buttons;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
